// File: rtl/pseudo_stk_pkg.sv
// Shared types for the pseudo-analog stick: channel modes, sweep FSM states, direction encoding.
package pseudo_stk_pkg;

  typedef enum logic [1:0] {
    SPRING = 2'd0,
    HOLD   = 2'd1,
    SNAP   = 2'd2,
    RSVD   = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    FIN   = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    DIR_NONE = 2'b00,
    DIR_POS  = 2'b01,
    DIR_NEG  = 2'b10
  } dir_e;

  // Both buttons or neither is a release.
  function automatic dir_e decode_dir(input logic inc, input logic dec);
    if (inc && !dec) return DIR_POS;
    if (dec && !inc) return DIR_NEG;
    return DIR_NONE;
  endfunction

endpackage

// File: rtl/pseudo_stk_axis.sv
// Combinational next-position for one axis: step, decay, snap and clamp.
// Hold-counter ports exist only when PSEUDO_STK_ACCEL_EN is defined.
module pseudo_stk_axis
  import pseudo_stk_pkg::*;
#(
  parameter int W    = 8,
  parameter int STEP = 15,
  parameter int LIM  = 120
`ifdef PSEUDO_STK_ACCEL_EN
  ,
  parameter int ACC_MAX = 3,
  parameter int HW      = 2
`endif
) (
  input  logic signed [W+3:0] acc,
  input  logic        [1:0]   dir,
  input  logic        [1:0]   mode,
`ifdef PSEUDO_STK_ACCEL_EN
  input  logic        [HW-1:0] h,
  input  logic        [1:0]    prev_dir,
  output logic        [HW-1:0] h_nxt,
`endif
  output logic signed [W+3:0] acc_nxt
);

  localparam logic signed [W+3:0] STEP_S = (W+4)'(STEP);
  localparam logic signed [W+3:0] LIM_S  = (W+4)'(LIM);

  logic signed [W+3:0] step;
  logic signed [W+3:0] sum;
  dir_e                d;

  assign d = dir_e'(dir);

  always_comb begin
    step = STEP_S;
`ifdef PSEUDO_STK_ACCEL_EN
    step = (W+4)'(STEP * (int'(h) + 1));
`endif
    sum = acc;
    case (mode_e'(mode))
      SNAP: begin
        if (d == DIR_POS)      sum = LIM_S;
        else if (d == DIR_NEG) sum = -LIM_S;
        else                   sum = '0;
      end
      HOLD: begin
        if (d == DIR_POS)      sum = acc + step;
        else if (d == DIR_NEG) sum = acc - step;
        else                   sum = acc;
      end
      default: begin
        if (d == DIR_POS)           sum = acc + step;
        else if (d == DIR_NEG)      sum = acc - step;
        else if (acc > STEP_S)      sum = acc - STEP_S;
        else if (acc < -STEP_S)     sum = acc + STEP_S;
        else                        sum = '0;
      end
    endcase

    if (sum > LIM_S)       acc_nxt = LIM_S;
    else if (sum < -LIM_S) acc_nxt = -LIM_S;
    else                   acc_nxt = sum;
  end

`ifdef PSEUDO_STK_ACCEL_EN
  // A press after a release starts counting; only a reversal restarts from zero.
  always_comb begin
    if (d == DIR_NONE)
      h_nxt = '0;
    else if (dir_e'(prev_dir) != DIR_NONE && dir_e'(prev_dir) != d)
      h_nxt = '0;
    else if (h == HW'(ACC_MAX - 1))
      h_nxt = h;
    else
      h_nxt = h + HW'(1);
  end
`endif

endmodule

// File: rtl/pseudo_analog_stick.sv
// Frame-triggered digital-to-pseudo-analog stick converter sweeping NCH channels through one shared datapath.
// Optional acceleration is compiled in with the PSEUDO_STK_ACCEL_EN macro.
module pseudo_analog_stick
  import pseudo_stk_pkg::*;
#(
  parameter int NCH       = 2,
  parameter int W         = 8,
  parameter int STEP      = 15,
  parameter int LIM       = 120,
  parameter int CENTER    = 127,
  parameter int TRIG_LINE = 0,
  parameter int ACC_MAX   = 3
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [8:0]         PV,
  input  logic [NCH-1:0]     INC,
  input  logic [NCH-1:0]     DEC,
  input  logic [2*NCH-1:0]   MODE,
  output logic [NCH*W-1:0]   AOUT,
  output logic               BUSY,
  output logic               DONE
);

  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CHW-1:0] LAST_CH = CHW'(NCH - 1);
  localparam logic signed [W+3:0] CENTER_S = (W+4)'(CENTER);

  if (NCH < 1 || NCH > 16 || STEP < 1 || LIM > CENTER ||
      CENTER + LIM >= (1 << W) || ACC_MAX < 1) begin : g_param_err
    $error("pseudo_analog_stick: illegal parameter set");
  end

  logic [8:0]          ppv;
  logic                trig;
  state_e              state, state_nxt;
  logic [CHW-1:0]      ch;

  logic signed [W+3:0] acc_q  [NCH];
  logic [W-1:0]        aout_q [NCH];

  logic [1:0]          cur_dir;
  logic [1:0]          cur_mode;
  logic signed [W+3:0] acc_nxt;
  logic [W-1:0]        aout_nxt;

  always_ff @(posedge CLK) begin
    if (RESET) ppv <= '0;
    else       ppv <= PV;
  end

  // Edge-qualified so a frame that parks PV on the trigger line fires once.
  assign trig = (PV != ppv) && (PV == 9'(TRIG_LINE));

  always_ff @(posedge CLK) begin
    if (RESET) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (trig) state_nxt = SWEEP;
      SWEEP:   if (ch == LAST_CH) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    BUSY = (state == SWEEP);
    DONE = (state == FIN);
  end

  always_ff @(posedge CLK) begin
    if (RESET)
      ch <= '0;
    else if (state == IDLE)
      ch <= '0;
    else if (state == SWEEP && ch != LAST_CH)
      ch <= ch + CHW'(1);
  end

  assign cur_dir  = decode_dir(INC[ch], DEC[ch]);
  assign cur_mode = MODE[{ch, 1'b0} +: 2];
  assign aout_nxt = W'(CENTER_S + acc_nxt);

`ifdef PSEUDO_STK_ACCEL_EN
  localparam int HW = (ACC_MAX > 1) ? $clog2(ACC_MAX) : 1;

  logic [HW-1:0] h_q  [NCH];
  logic [1:0]    pd_q [NCH];
  logic [HW-1:0] h_nxt;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int k = 0; k < NCH; k++) begin
        h_q[k]  <= '0;
        pd_q[k] <= DIR_NONE;
      end
    end else if (state == SWEEP) begin
      h_q[ch]  <= h_nxt;
      pd_q[ch] <= cur_dir;
    end
  end

  pseudo_stk_axis #(
    .W(W), .STEP(STEP), .LIM(LIM), .ACC_MAX(ACC_MAX), .HW(HW)
  ) u_axis (
    .acc      (acc_q[ch]),
    .dir      (cur_dir),
    .mode     (cur_mode),
    .h        (h_q[ch]),
    .prev_dir (pd_q[ch]),
    .h_nxt    (h_nxt),
    .acc_nxt  (acc_nxt)
  );
`else
  pseudo_stk_axis #(
    .W(W), .STEP(STEP), .LIM(LIM)
  ) u_axis (
    .acc     (acc_q[ch]),
    .dir     (cur_dir),
    .mode    (cur_mode),
    .acc_nxt (acc_nxt)
  );
`endif

  // Output lanes are registered alongside the position so AOUT never sees the adder.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int k = 0; k < NCH; k++) begin
        acc_q[k]  <= '0;
        aout_q[k] <= W'(CENTER);
      end
    end else if (state == SWEEP) begin
      acc_q[ch]  <= acc_nxt;
      aout_q[ch] <= aout_nxt;
    end
  end

  for (genvar k = 0; k < NCH; k++) begin : g_lane
    assign AOUT[W*k +: W] = aout_q[k];
  end

endmodule
